// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_CNT_W = 1;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry into the top cell.
module digit_adder
    import adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, LSB digit first, with a start/ready/done handshake.
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   RUN   | one digit per cycle through digit_adder, ready=0
//   DONE  | s/co/ovf just updated, done=1, ready=1 (back-to-back start allowed)
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dcout, dcmsb;
    logic             accept, last;

    assign accept = start & ready;
    assign last   = (state == RUN) && (cnt == LAST);

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // Sum digits enter at the top so the LSB digit lands at bit 0 after NDIG shifts.
    if (DIGIT == WIDTH) begin : g_full
        assign psum_nxt = dsum;
    end else begin : g_shift
        assign psum_nxt = {dsum, psum[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        done  = 1'b0;
        case (state)
            RUN:     ready = 1'b0;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub | ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            psum  <= psum_nxt;
            carry <= dcout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                s   <= psum_nxt;
                co  <= dcout;
                ovf <= dcout ^ dcmsb;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: several serial_adder configurations against an arithmetic reference model.
module tb_serial_adder;

    localparam int NCFG = 8;

    function automatic int wcfg(input int i);
        case (i)
            0: return 8;   1: return 16;  2: return 32;  3: return 8;
            4: return 8;   5: return 16;  6: return 32;  default: return 16;
        endcase
    endfunction

    function automatic int dcfg(input int i);
        case (i)
            0: return 1;   1: return 4;   2: return 8;   3: return 2;
            4: return 8;   5: return 1;   6: return 2;   default: return 8;
        endcase
    endfunction

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCFG-1:0] start_v, sub_v, ci_v, ready_v, done_v, co_v, ovf_v;
    logic [31:0]     a_v [NCFG];
    logic [31:0]     b_v [NCFG];
    logic [31:0]     s_v [NCFG];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = wcfg(g);
        localparam int D = dcfg(g);
        logic [W-1:0] s_w;
        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .sub   (sub_v[g]),
            .a     (a_v[g][W-1:0]),
            .b     (b_v[g][W-1:0]),
            .ci    (ci_v[g]),
            .ready (ready_v[g]),
            .done  (done_v[g]),
            .s     (s_w),
            .co    (co_v[g]),
            .ovf   (ovf_v[g])
        );
        assign s_v[g] = 32'(s_w);
    end

    function automatic longint to_signed(input longint x, input int w);
        longint lim = longint'(1) << w;
        return (x >= lim / 2) ? x - lim : x;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_op(input int w, input logic is_sub, input logic [31:0] aa,
                                   input logic [31:0] bb, input logic cc,
                                   output logic [31:0] rs, output logic rco, output logic rovf);
        longint lim, ua, ub, us, ss;
        lim = longint'(1) << w;
        ua  = longint'(aa) & (lim - 1);
        ub  = longint'(bb) & (lim - 1);
        if (is_sub) begin
            us  = ua - ub;
            ss  = to_signed(ua, w) - to_signed(ub, w);
            rco = (ua >= ub);
        end else begin
            us  = ua + ub + longint'(cc);
            ss  = to_signed(ua, w) + to_signed(ub, w) + longint'(cc);
            rco = (us >= lim);
        end
        rs   = 32'(us & (lim - 1));
        rovf = (ss < -(lim / 2)) || (ss >= lim / 2);
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Drives one operation (start asserted just after edge T, sampled at edge T+1) and
    // reports the done latency in cycles after the sampling edge; lat=-1 on timeout.
    task automatic run_op(input int i, input logic is_sub, input logic [31:0] aa,
                          input logic [31:0] bb, input logic cc,
                          output int lat, output int rdy_low, output logic extra_done,
                          output logic s_early);
        logic [31:0] s0;
        @(posedge clk); #1;
        sub_v[i] = is_sub; a_v[i] = aa; b_v[i] = bb; ci_v[i] = cc; start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        a_v[i] = $urandom; b_v[i] = $urandom; ci_v[i] = 1'($urandom); sub_v[i] = 1'($urandom);
        s0 = s_v[i];
        lat = -1; rdy_low = 0; extra_done = 1'b0; s_early = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                lat = k;
                break;
            end
            if (!ready_v[i]) rdy_low++;
            if (s_v[i] !== s0) s_early = 1'b1;
        end
        if (lat >= 0) begin
            @(negedge clk);
            extra_done = done_v[i];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_v = '0; sub_v = '0; ci_v = '0;
        for (int i = 0; i < NCFG; i++) begin
            a_v[i] = '0; b_v[i] = '0;
        end
        #12;
        for (int i = 0; i < NCFG; i++) begin
            n_checks++;
            if ({ready_v[i], done_v[i], co_v[i], ovf_v[i]} !== 4'b1000) begin
                n_errors++;
                $display("FAIL reset_ctrl cfg%0d: ready/done/co/ovf=%b expected 1000", i,
                         {ready_v[i], done_v[i], co_v[i], ovf_v[i]});
            end
            n_checks++;
            if (s_v[i] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_s cfg%0d: s=%0h expected 0", i, s_v[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed_dig1();
        int lat, rl;
        logic xd, se;
        logic [31:0] ea [3] = '{32'hFF, 32'h7F, 32'h05};
        logic [31:0] eb [3] = '{32'h01, 32'h01, 32'h07};
        logic        esub [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'h00, 32'h80, 32'hFE};
        logic        eco [3] = '{1'b1, 1'b0, 1'b0};
        logic        eov [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            run_op(0, esub[t], ea[t], eb[t], 1'b0, lat, rl, xd, se);
            n_checks++;
            if (lat !== 8) begin
                n_errors++;
                $display("FAIL dig1_latency case%0d: %0d expected 8", t, lat);
            end
            n_checks++;
            if (rl !== 8) begin
                n_errors++;
                $display("FAIL dig1_ready_low case%0d: %0d cycles expected 8", t, rl);
            end
            n_checks++;
            if ({s_v[0], co_v[0], ovf_v[0]} !== {es[t], eco[t], eov[t]}) begin
                n_errors++;
                $display("FAIL dig1_result case%0d: s=%0h co=%b ovf=%b expected s=%0h co=%b ovf=%b",
                         t, s_v[0], co_v[0], ovf_v[0], es[t], eco[t], eov[t]);
            end
            n_checks++;
            if (xd !== 1'b0 || se !== 1'b0) begin
                n_errors++;
                $display("FAIL dig1_pulse case%0d: extra_done=%b early_s_change=%b expected 0 0", t, xd, se);
            end
        end
    endtask

    task automatic test_directed_dig4();
        int lat, rl;
        logic xd, se;
        run_op(1, 1'b0, 32'h1234, 32'hEDCB, 1'b1, lat, rl, xd, se);
        n_checks++;
        if (lat !== 4) begin
            n_errors++;
            $display("FAIL dig4_latency: %0d expected 4", lat);
        end
        n_checks++;
        if ({s_v[1], co_v[1], ovf_v[1]} !== {32'h0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL dig4_result: s=%0h co=%b ovf=%b expected s=0 co=1 ovf=0",
                     s_v[1], co_v[1], ovf_v[1]);
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int late_done = 0;
        @(posedge clk); #1;
        sub_v[0] = 1'b0; a_v[0] = 32'h3C; b_v[0] = 32'h05; ci_v[0] = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 2) begin
                a_v[0] = 32'hAA; b_v[0] = 32'h55; sub_v[0] = 1'b1; start_v[0] = 1'b1;
            end
            if (k == 3) start_v[0] = 1'b0;
            if (done_v[0]) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 8 || s_v[0] !== 32'h42) begin
            n_errors++;
            $display("FAIL ignore_start: lat=%0d s=%0h expected lat=8 s=42", lat, s_v[0]);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v[0]) late_done++;
        end
        n_checks++;
        if (late_done !== 0) begin
            n_errors++;
            $display("FAIL ignore_start_queued: %0d extra done pulses expected 0", late_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        int lat2 = -1;
        @(posedge clk); #1;
        sub_v[0] = 1'b0; a_v[0] = 32'h01; b_v[0] = 32'h02; ci_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_v[0]) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 8 || s_v[0] !== 32'h03) begin
            n_errors++;
            $display("FAIL b2b_first: lat=%0d s=%0h expected lat=8 s=3", lat, s_v[0]);
        end
        a_v[0] = 32'h10; b_v[0] = 32'h20; sub_v[0] = 1'b0; ci_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (done_v[0]) begin
                lat2 = k;
                break;
            end
        end
        n_checks++;
        if (lat2 !== 9 || s_v[0] !== 32'h30) begin
            n_errors++;
            $display("FAIL b2b_second: cycles=%0d s=%0h expected cycles=9 s=30", lat2, s_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, rl, stray = 0;
        logic xd, se;
        @(posedge clk); #1;
        sub_v[0] = 1'b0; a_v[0] = 32'h55; b_v[0] = 32'h0F; ci_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready_v[0], done_v[0], s_v[0], co_v[0], ovf_v[0]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL midrun_reset: ready=%b done=%b s=%0h co=%b ovf=%b expected 1 0 0 0 0",
                     ready_v[0], done_v[0], s_v[0], co_v[0], ovf_v[0]);
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v[0]) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL midrun_stray_done: %0d pulses expected 0", stray);
        end
        run_op(0, 1'b0, 32'h55, 32'h0F, 1'b0, lat, rl, xd, se);
        n_checks++;
        if (lat !== 8 || s_v[0] !== 32'h64 || co_v[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_recover: lat=%0d s=%0h co=%b expected lat=8 s=64 co=0",
                     lat, s_v[0], co_v[0]);
        end
    endtask

    task automatic test_random();
        int lat, rl, w, nd;
        logic xd, se, is_sub, cc, rco, rovf;
        logic [31:0] m, aa, bb, rs;
        for (int i = 0; i < NCFG; i++) begin
            w  = wcfg(i);
            nd = w / dcfg(i);
            m  = wmask(w);
            for (int t = 0; t < 15; t++) begin
                is_sub = 1'($urandom);
                cc     = 1'($urandom);
                case ($urandom_range(0, 5))
                    0:       aa = 32'h0;
                    1:       aa = m;
                    2:       aa = (m >> 1) + 32'd1;
                    default: aa = $urandom & m;
                endcase
                case ($urandom_range(0, 5))
                    0:       bb = 32'h0;
                    1:       bb = m;
                    2:       bb = m >> 1;
                    default: bb = $urandom & m;
                endcase
                ref_op(w, is_sub, aa, bb, cc, rs, rco, rovf);
                run_op(i, is_sub, aa, bb, cc, lat, rl, xd, se);
                n_checks++;
                if (lat !== nd) begin
                    n_errors++;
                    $display("FAIL rand_latency cfg%0d op%0d: %0d expected %0d", i, t, lat, nd);
                end
                n_checks++;
                if (s_v[i] !== rs) begin
                    n_errors++;
                    $display("FAIL rand_s cfg%0d op%0d sub=%b a=%0h b=%0h ci=%b: s=%0h expected %0h",
                             i, t, is_sub, aa, bb, cc, s_v[i], rs);
                end
                n_checks++;
                if ({co_v[i], ovf_v[i]} !== {rco, rovf}) begin
                    n_errors++;
                    $display("FAIL rand_flags cfg%0d op%0d sub=%b a=%0h b=%0h ci=%b: co/ovf=%b%b expected %b%b",
                             i, t, is_sub, aa, bb, cc, co_v[i], ovf_v[i], rco, rovf);
                end
                n_checks++;
                if (xd !== 1'b0 || se !== 1'b0 || rl !== nd) begin
                    n_errors++;
                    $display("FAIL rand_handshake cfg%0d op%0d: extra_done=%b early_s=%b ready_low=%0d expected 0 0 %0d",
                             i, t, xd, se, rl, nd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_dig1();
        test_directed_dig4();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
